systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Transmit-side operand feeder for the N x N systolic matrix-multiply array; drives the a (west edge) and b (north edge) operand inputs and per-lane enables of the edge PEs.
- Accepts the K inner-dimension beats of A (column-wise) and B (row-wise) over a valid/ready load interface and buffers them.
- Replays the beats with the diagonal skew the array needs: lane i is delayed by i cycles.
- Sequences accumulator clear, stream and drain, then pulses done.

Parameters:
- DATA_WIDTH, 8, operand width (matches PE input width).
- N, 4, array dimension (number of a lanes = number of b lanes).
- K, 4, inner dimension (beats per job), K >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  load beat valid.
- in_ready  output  1  feeder can accept a load beat.
- in_a  input  N*DATA_WIDTH  beat k: lane i = A[i][k] at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_b  input  N*DATA_WIDTH  beat k: lane j = B[k][j].
- a_out  output  N*DATA_WIDTH  west-edge operands, lane i to array row i.
- b_out  output  N*DATA_WIDTH  north-edge operands, lane j to array column j.
- a_en  output  N  per-row operand-valid / PE enable.
- b_en  output  N  per-column operand-valid.
- acc_clr  output  1  one-cycle accumulator clear to the array.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle job-complete pulse.

Behaviour:
- All outputs are registered. Single clock. Reset is synchronous and active-high.
- Reset values: a_out=0, b_out=0, a_en=0, b_en=0, acc_clr=0, busy=0, done=0, in_ready=1, state=IDLE, counters=0.
- A handshake occurs on any cycle with in_valid && in_ready. in_ready=1 only in IDLE and LOAD.
- IDLE: a handshake stores beat 0.
  - K==1 -> CLEAR.
  - Otherwise -> LOAD with beat_cnt=1.
- LOAD: each handshake stores beat beat_cnt and increments it. The handshake storing beat K-1 -> CLEAR. in_valid=0 holds LOAD indefinitely.
- CLEAR: exactly 1 cycle. acc_clr=1, all operands and enables 0, in_ready=0. -> STREAM with s=0.
- STREAM: lasts K+N-1 cycles, with s = 0..K+N-2.
  - Lane i: a_out[i]=A[i][s-i] and a_en[i]=1 if 0 <= s-i < K; else a_out[i]=0 and a_en[i]=0.
  - Lane j: b_out[j]=B[s-j][j] and b_en[j]=1 under the same window rule.
  - After s=K+N-2 -> DRAIN.
- DRAIN: N-1 cycles (skipped when N==1), all operands 0 and enables 0, letting in-flight operands propagate through the array. -> IDLE.
- done: 1 in the first IDLE cycle after DRAIN (1 after STREAM when N==1). in_ready is also 1 in that cycle, so a beat 0 handshake there is legal (back-to-back jobs).
- Latency: the first stream value appears 2 cycles after the final load handshake. busy is high from the cycle after the beat-0 handshake through the last DRAIN cycle.
- Operand values pass through unmodified, no arithmetic. Zero-fill outside each lane window.
- Counter widths: $clog2(K+N) for s/drain, $clog2(K)+1 for beat_cnt.
- in_valid while busy and not in LOAD: ignored, buffer unchanged.
- Reset mid-job, in any state: next cycle all outputs are at reset values and state=IDLE. Buffer contents are don't-care. done is not asserted.

Decomposition:
- matmul_pkg holds:
  - the feeder_state_t enum {IDLE, LOAD, CLEAR, STREAM, DRAIN};
  - DATA_WIDTH default constant, shared with pe;
  - the lane-slice helper function.
- Sub-module operand_bank: K x N register bank with write-by-beat and read-by-(lane, index). Instantiated twice, once for A and once for B.

Test Plan:
- N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]; beats in_a={1,3},{2,4}, in_b={5,6},{7,8} -> acc_clr pulses 1 cycle after the last handshake, then:
  - s0: a_out={1,0}, a_en=01, b_out={5,0}, b_en=01.
  - s1: a_out={2,3}, a_en=11, b_out={7,6}, b_en=11.
  - s2: a_out={0,4}, a_en=10, b_out={0,8}, b_en=10.
  - 1 DRAIN cycle, then done=1.
- Same job with in_valid toggling 1,0,0,1 -> LOAD holds 2 idle cycles and the stream matches scenario 1 exactly.
- in_valid held high from the cycle of done -> new beat 0 accepted in the done cycle; second job streams correctly.
- in_valid=1 during CLEAR/STREAM with junk data 0xFF -> in_ready=0 and the streamed values are unchanged.
- rst asserted during STREAM s=1 -> next cycle a_en=b_en=0, outputs 0, busy=0, in_ready=1, and done never pulses.
- N=4, K=1, A column {9,8,7,6} -> lane i carries its value only at s=i. STREAM lasts 4 cycles, DRAIN 3, then done.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic matrix-multiply datapath:
// feeder FSM states, PE operand width and lane slicing helpers.
package matmul_pkg;

    localparam int PE_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        STREAM,
        DRAIN
    } feeder_state_t;

    // LSB position of a lane inside a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Index width for a buffer of the given depth; never narrower than 1 bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/operand_bank.sv
// K x N operand register bank: a whole beat is written at once, and each
// lane reads its own beat index independently so skewed replay is possible.
module operand_bank
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int N          = 4,
    parameter int K          = 4,
    localparam int IDX_W     = idx_width(K)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [N*DATA_WIDTH-1:0]      wr_data,
    input  logic [N-1:0][IDX_W-1:0]      rd_idx,
    output logic [N*DATA_WIDTH-1:0]      rd_data
);

    logic [N*DATA_WIDTH-1:0] mem [K];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane_rd
        assign rd_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
            mem[rd_idx[gi]][lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array: buffers K beats of A and B,
// then replays them with a per-lane diagonal skew around clear and drain.
module systolic_feeder
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int N          = 4,
    parameter int K          = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a,
    input  logic [N*DATA_WIDTH-1:0] in_b,
    output logic [N*DATA_WIDTH-1:0] a_out,
    output logic [N*DATA_WIDTH-1:0] b_out,
    output logic [N-1:0]            a_en,
    output logic [N-1:0]            b_en,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = idx_width(K);
    localparam int SW    = $clog2(K + N);
    localparam int BW    = $clog2(K) + 1;

    feeder_state_t state_reg;
    logic [BW-1:0] beat_cnt_reg;
    logic [SW-1:0] s_reg;
    logic [SW-1:0] drain_cnt_reg;

    logic                    hs;
    logic [IDX_W-1:0]        wr_idx;
    logic [SW-1:0]           s_next;
    logic [N-1:0]            lane_on;
    logic [N-1:0][IDX_W-1:0] rd_idx;
    logic [N*DATA_WIDTH-1:0] a_rd, b_rd, a_gated, b_gated;

    assign hs     = in_valid && in_ready;
    assign wr_idx = (state_reg == LOAD) ? IDX_W'(beat_cnt_reg) : '0;
    // Outputs are registered, so the bank is read for the step about to be shown.
    assign s_next = (state_reg == STREAM) ? s_reg + 1'b1 : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        assign lane_on[gi] = (int'(s_next) >= gi) && (int'(s_next) - gi < K);
        assign rd_idx[gi]  = lane_on[gi] ? IDX_W'(int'(s_next) - gi) : '0;
        assign a_gated[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
            lane_on[gi] ? a_rd[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] : '0;
        assign b_gated[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
            lane_on[gi] ? b_rd[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] : '0;
    end

    operand_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .K(K)) u_bank_a (
        .clk     (clk),
        .wr_en   (hs),
        .wr_idx  (wr_idx),
        .wr_data (in_a),
        .rd_idx  (rd_idx),
        .rd_data (a_rd)
    );

    operand_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .K(K)) u_bank_b (
        .clk     (clk),
        .wr_en   (hs),
        .wr_idx  (wr_idx),
        .wr_data (in_b),
        .rd_idx  (rd_idx),
        .rd_data (b_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            s_reg         <= '0;
            drain_cnt_reg <= '0;
            a_out         <= '0;
            b_out         <= '0;
            a_en          <= '0;
            b_en          <= '0;
            acc_clr       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            in_ready      <= 1'b1;
        end else begin
            // Operands, enables and pulses are zero unless a state drives them.
            a_out   <= '0;
            b_out   <= '0;
            a_en    <= '0;
            b_en    <= '0;
            acc_clr <= 1'b0;
            done    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hs) begin
                        busy <= 1'b1;
                        if (K == 1) begin
                            state_reg <= CLEAR;
                            acc_clr   <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state_reg    <= LOAD;
                            beat_cnt_reg <= BW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        if (beat_cnt_reg == BW'(K - 1)) begin
                            state_reg <= CLEAR;
                            acc_clr   <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state_reg <= STREAM;
                    s_reg     <= '0;
                    a_out     <= a_gated;
                    b_out     <= b_gated;
                    a_en      <= lane_on;
                    b_en      <= lane_on;
                end
                STREAM: begin
                    if (s_reg == SW'(K + N - 2)) begin
                        if (N > 1) begin
                            state_reg     <= DRAIN;
                            drain_cnt_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            done      <= 1'b1;
                        end
                    end else begin
                        s_reg <= s_next;
                        a_out <= a_gated;
                        b_out <= b_gated;
                        a_en  <= lane_on;
                        b_en  <= lane_on;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == SW'(N - 2)) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus queues expected output
// cycles, per-DUT monitors pop and compare whenever the feeder is active.
module tb_systolic_feeder;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ae;
        logic [3:0]  be;
        logic        clr;
        logic        busy;
        logic        done;
        logic        rdy;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=2, K=2 instance
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [15:0] in_a2 = '0, in_b2 = '0;
    logic [15:0] a_out2, b_out2;
    logic [1:0]  a_en2, b_en2;
    logic        acc_clr2, busy2, done2;

    // N=4, K=1 instance
    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [31:0] in_a4 = '0, in_b4 = '0;
    logic [31:0] a_out4, b_out4;
    logic [3:0]  a_en4, b_en4;
    logic        acc_clr4, busy4, done4;

    systolic_feeder #(.DATA_WIDTH(8), .N(2), .K(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .a_out(a_out2), .b_out(b_out2),
        .a_en(a_en2), .b_en(b_en2), .acc_clr(acc_clr2), .busy(busy2), .done(done2)
    );

    systolic_feeder #(.DATA_WIDTH(8), .N(4), .K(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .a_out(a_out4), .b_out(b_out4),
        .a_en(a_en4), .b_en(b_en4), .acc_clr(acc_clr4), .busy(busy4), .done(done4)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    rec_t q2[$];
    rec_t q4[$];

    function automatic rec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] ae, input logic [3:0] be,
                                input logic clr, input logic bsy,
                                input logic dn, input logic rdy);
        rec_t r;
        r.a = a; r.b = b; r.ae = ae; r.be = be;
        r.clr = clr; r.busy = bsy; r.done = dn; r.rdy = rdy;
        return r;
    endfunction

    function automatic rec_t act2();
        return mk({16'h0, a_out2}, {16'h0, b_out2}, {2'b0, a_en2}, {2'b0, b_en2},
                  acc_clr2, busy2, done2, in_ready2);
    endfunction

    function automatic rec_t act4();
        return mk(a_out4, b_out4, a_en4, b_en4, acc_clr4, busy4, done4, in_ready4);
    endfunction

    task automatic check_rec(input string name, input rec_t got, input rec_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got a=%h b=%h ae=%b be=%b clr=%b busy=%b done=%b rdy=%b, expected a=%h b=%h ae=%b be=%b clr=%b busy=%b done=%b rdy=%b",
                     name, got.a, got.b, got.ae, got.be, got.clr, got.busy, got.done, got.rdy,
                     exp.a, exp.b, exp.ae, exp.be, exp.clr, exp.busy, exp.done, exp.rdy);
        end
    endtask

    task automatic check_bits(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, got, exp);
    endtask

    // Active cycles: CLEAR/STREAM/DRAIN (busy, not ready) and the done cycle.
    always @(negedge clk) begin : mon2
        rec_t e;
        if ((busy2 && !in_ready2) || done2) begin
            if (q2.size() == 0) begin
                n_checks++;
                $display("FAIL mon2_unexpected: got a=%h b=%h clr=%b busy=%b done=%b, expected no activity",
                         a_out2, b_out2, acc_clr2, busy2, done2);
            end else begin
                e = q2.pop_front();
                check_rec("mon2", act2(), e);
                $display("mon2 t=%0t a=%h b=%h ae=%b be=%b clr=%b done=%b", $time,
                         a_out2, b_out2, a_en2, b_en2, acc_clr2, done2);
            end
        end
    end

    always @(negedge clk) begin : mon4
        rec_t e;
        if ((busy4 && !in_ready4) || done4) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL mon4_unexpected: got a=%h b=%h clr=%b busy=%b done=%b, expected no activity",
                         a_out4, b_out4, acc_clr4, busy4, done4);
            end else begin
                e = q4.pop_front();
                check_rec("mon4", act4(), e);
                $display("mon4 t=%0t a=%h b=%h ae=%b be=%b clr=%b done=%b", $time,
                         a_out4, b_out4, a_en4, b_en4, acc_clr4, done4);
            end
        end
    end

    // Present one load beat and hold it until accepted (bounded wait).
    task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        if (sel == 2) begin
            in_valid2 = 1'b1; in_a2 = a[15:0]; in_b2 = b[15:0];
        end else begin
            in_valid4 = 1'b1; in_a4 = a; in_b4 = b;
        end
        @(negedge clk);
        while (!((sel == 2) ? in_ready2 : in_ready4) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_bits("load_accept", {3'b0, (sel == 2) ? in_ready2 : in_ready4}, 4'b0001);
        @(posedge clk);
        #1;
        if (sel == 2) in_valid2 = 1'b0;
        else in_valid4 = 1'b0;
    endtask

    // Expected cycles of one 2x2 job; 'full' = 0 stops after stream step 1.
    task automatic push_job2(input logic [15:0] a0, input logic [15:0] b0,
                             input logic [15:0] a1, input logic [15:0] b1,
                             input logic [15:0] a2, input logic [15:0] b2,
                             input bit full);
        q2.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 0, 0));
        q2.push_back(mk({16'h0, a0}, {16'h0, b0}, 4'b0001, 4'b0001, 0, 1, 0, 0));
        q2.push_back(mk({16'h0, a1}, {16'h0, b1}, 4'b0011, 4'b0011, 0, 1, 0, 0));
        if (full) begin
            q2.push_back(mk({16'h0, a2}, {16'h0, b2}, 4'b0010, 4'b0010, 0, 1, 0, 0));
            q2.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0));
            q2.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1));
        end
    endtask

    task automatic wait_empty(input int sel);
        int n;
        n = 0;
        while (((sel == 2) ? q2.size() : q4.size()) > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (((sel == 2) ? q2.size() : q4.size()) == 0) n_pass++;
        else $display("FAIL drain_timeout_%0d: got %0d pending, expected 0",
                      sel, (sel == 2) ? q2.size() : q4.size());
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        rec_t rst_rec;
        rst_rec = mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_rec("reset2", act2(), rst_rec);
        check_rec("reset4", act4(), rst_rec);
        @(posedge clk); #1;

        // Basic 2x2 job
        $display("job basic");
        send(2, 32'h0301, 32'h0605);
        send(2, 32'h0402, 32'h0807);
        push_job2(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, 1);
        wait_empty(2);

        // in_valid pattern 1,0,0,1: LOAD must hold through the gap
        $display("job gaps");
        send(2, 32'h0301, 32'h0605);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_bits("load_hold", {1'b0, busy2, in_ready2, acc_clr2}, 4'b0110);
            @(posedge clk); #1;
        end
        send(2, 32'h0402, 32'h0807);
        push_job2(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, 1);
        wait_empty(2);

        // Junk beats offered while busy must be refused and change nothing
        $display("job junk");
        send(2, 32'h0301, 32'h0605);
        send(2, 32'h0402, 32'h0807);
        push_job2(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, 1);
        in_valid2 = 1'b1; in_a2 = 16'hFFFF; in_b2 = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bits("junk_refused", {3'b0, in_ready2}, 4'b0000);
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
        wait_empty(2);

        // Back-to-back: next beat 0 is held and accepted in the done cycle
        $display("job back_to_back");
        send(2, 32'h0301, 32'h0605);
        send(2, 32'h0402, 32'h0807);
        push_job2(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, 1);
        send(2, 32'h0C0A, 32'h1514);
        @(negedge clk);
        check_bits("b2b_load", {2'b0, busy2, in_ready2}, 4'b0011);
        @(posedge clk); #1;
        send(2, 32'h0D0B, 32'h1716);
        push_job2(16'h000A, 16'h0014, 16'h0C0B, 16'h1516, 16'h0D00, 16'h1700, 1);
        wait_empty(2);

        // Reset during stream step 1
        $display("job reset");
        send(2, 32'h0301, 32'h0605);
        send(2, 32'h0402, 32'h0807);
        push_job2(16'h0001, 16'h0005, 16'h0302, 16'h0607, 16'h0400, 16'h0800, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_rec("reset_midjob", act2(), rst_rec);
        repeat (10) @(negedge clk);
        check_bits("reset_q_empty", {3'b0, q2.size() == 0}, 4'b0001);
        @(posedge clk); #1;

        // N=4, K=1: lane i active only at step i
        $display("job n4k1");
        send(4, 32'h06070809, 32'h01020304);
        q4.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 1, 0, 0));
        q4.push_back(mk(32'h00000009, 32'h00000004, 4'b0001, 4'b0001, 0, 1, 0, 0));
        q4.push_back(mk(32'h00000800, 32'h00000300, 4'b0010, 4'b0010, 0, 1, 0, 0));
        q4.push_back(mk(32'h00070000, 32'h00020000, 4'b0100, 4'b0100, 0, 1, 0, 0));
        q4.push_back(mk(32'h06000000, 32'h01000000, 4'b1000, 4'b1000, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) q4.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 1, 0, 0));
        q4.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1));
        wait_empty(4);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
